// File: rtl/icache_dm.sv
// Direct-mapped instruction cache holding one 32-bit word per line.
// A hit answers in one cycle. A miss issues a single word read to mem_ctrl.
module icache_dm #(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 6,
  parameter int BYPASS     = 0
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  if_req_in,
  input  logic [ADDR_WIDTH-1:0] if_addr_in,
  input  logic                  if_cancel_in,
  input  logic                  flush_in,
  output logic                  if_ready_out,
  output logic                  if_valid_out,
  output logic [31:0]           if_data_out,
  output logic                  mc_req_out,
  output logic [ADDR_WIDTH-1:0] mc_addr_out,
  input  logic                  mc_valid_in,
  input  logic [31:0]           mc_data_in
);

  // state  | meaning
  // IDLE   | lookup; a hit is answered on the next cycle
  // MISS   | word read outstanding at mem_ctrl; waiting for mc_valid_in
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MISS = 1'b1;

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;
  localparam bit USE_CACHE = (BYPASS == 0);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~(ADDR_WIDTH'(3));

  logic [0:0]            state_q, state_d;
  logic [LINES-1:0]      valid_q, valid_d;
  logic                  cancel_q, cancel_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  if_valid_q, if_valid_d;
  logic [31:0]           if_data_q, if_data_d;
  logic                  mc_req_q, mc_req_d;
  logic [ADDR_WIDTH-1:0] mc_addr_q, mc_addr_d;

  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES];

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_W-1:0]      req_tag, fill_tag;
  logic                  lookup_hit;
  logic                  line_we;

  assign req_idx  = if_addr_in[INDEX_BITS+1:2];
  assign req_tag  = if_addr_in[ADDR_WIDTH-1:INDEX_BITS+2];
  assign fill_idx = mc_addr_q[INDEX_BITS+1:2];
  assign fill_tag = mc_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];

  // A flush in the same cycle turns the lookup into a miss.
  assign lookup_hit = USE_CACHE && valid_q[req_idx] && (tag_mem[req_idx] == req_tag) && !flush_in;

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    cancel_d     = cancel_q;
    flush_pend_d = flush_pend_q;
    if_valid_d   = if_valid_q;
    if_data_d    = if_data_q;
    mc_req_d     = mc_req_q;
    mc_addr_d    = mc_addr_q;
    line_we      = 1'b0;
    if (rdy_in) begin
      if_valid_d = 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req_in) begin
            if (lookup_hit) begin
              if_valid_d = !if_cancel_in;
              if_data_d  = data_mem[req_idx];
            end else begin
              state_d   = S_MISS;
              mc_req_d  = 1'b1;
              mc_addr_d = if_addr_in & WORD_MASK;
            end
          end
        end
        S_MISS: begin
          if (if_cancel_in) cancel_d = 1'b1;
          if (flush_in) flush_pend_d = 1'b1;
          if (mc_valid_in) begin
            // A flush seen at any point of this miss keeps the returned word out of the array.
            line_we      = USE_CACHE && !flush_in && !flush_pend_q;
            state_d      = S_IDLE;
            mc_req_d     = 1'b0;
            cancel_d     = 1'b0;
            flush_pend_d = 1'b0;
            if (!(cancel_q || if_cancel_in)) begin
              if_valid_d = 1'b1;
              if_data_d  = mc_data_in;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (flush_in && USE_CACHE) valid_d = '0;
      if (line_we) valid_d[fill_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      valid_q      <= '0;
      cancel_q     <= 1'b0;
      flush_pend_q <= 1'b0;
      if_valid_q   <= 1'b0;
      if_data_q    <= '0;
      mc_req_q     <= 1'b0;
      mc_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      cancel_q     <= cancel_d;
      flush_pend_q <= flush_pend_d;
      if_valid_q   <= if_valid_d;
      if_data_q    <= if_data_d;
      mc_req_q     <= mc_req_d;
      mc_addr_q    <= mc_addr_d;
    end
  end

  // Tag and data arrays carry no reset; the valid bits guard them.
  always_ff @(posedge clk_in) begin
    if (line_we) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mc_data_in;
    end
  end

  assign if_ready_out = (state_q == S_IDLE) && rst_n_in;
  assign if_valid_out = if_valid_q;
  assign if_data_out  = if_data_q;
  assign mc_req_out   = mc_req_q;
  assign mc_addr_out  = mc_addr_q;

endmodule

// File: tb/tb_icache_dm.sv
// Bench for icache_dm: directed scenarios plus random accesses checked
// against a line-array model of the cache; a second instance uses BYPASS=1.
module tb_icache_dm;

  logic        clk = 1'b0;
  logic        rst_n, rdy;
  logic        req, cancel, flush, mc_valid;
  logic [31:0] addr, mc_data;
  logic        ready, ivalid, mc_req;
  logic [31:0] idata, mc_addr;

  logic        b_req, b_cancel, b_flush, b_mc_valid;
  logic [31:0] b_addr, b_mc_data;
  logic        b_ready, b_ivalid, b_mc_req;
  logic [31:0] b_idata, b_mc_addr;

  int n_chk = 0;
  int n_fail = 0;

  bit          m_valid [64];
  logic [23:0] m_tag   [64];
  logic [31:0] m_data  [64];

  always #5 clk = ~clk;

  icache_dm #(.ADDR_WIDTH(32), .INDEX_BITS(6), .BYPASS(0)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .if_req_in(req), .if_addr_in(addr), .if_cancel_in(cancel), .flush_in(flush),
    .if_ready_out(ready), .if_valid_out(ivalid), .if_data_out(idata),
    .mc_req_out(mc_req), .mc_addr_out(mc_addr),
    .mc_valid_in(mc_valid), .mc_data_in(mc_data)
  );

  icache_dm #(.ADDR_WIDTH(32), .INDEX_BITS(6), .BYPASS(1)) dut_byp (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
    .if_req_in(b_req), .if_addr_in(b_addr), .if_cancel_in(b_cancel), .flush_in(b_flush),
    .if_ready_out(b_ready), .if_valid_out(b_ivalid), .if_data_out(b_idata),
    .mc_req_out(b_mc_req), .mc_addr_out(b_mc_addr),
    .mc_valid_in(b_mc_valid), .mc_data_in(b_mc_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[a[7:2]] && (m_tag[a[7:2]] == a[31:8]);
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  // One fetch. Miss path: cycle k of the wait (0..wait_n) may carry cancel/flush;
  // mc_valid arrives in cycle wait_n.
  task automatic access(input logic [31:0] a, input logic [31:0] fill, input int wait_n,
                        input int cancel_at, input int flush_at, input bit req_cancel, input bit req_flush);
    int idx;
    bit hit, cancelled, flushed;
    idx = int'(a[7:2]);
    chk("ready_idle", ready, 1);
    if (req_flush) m_clear();
    hit = m_hit(a);
    req = 1'b1; addr = a; cancel = hit & req_cancel; flush = req_flush;
    @(negedge clk);
    req = 1'b0; cancel = 1'b0; flush = 1'b0; addr = $urandom;
    if (hit) begin
      chk("hit_valid", ivalid, !req_cancel);
      if (!req_cancel) chk("hit_data", idata, m_data[idx]);
      chk("hit_no_mc_req", mc_req, 0);
      chk("hit_ready", ready, 1);
    end else begin
      cancelled = 1'b0; flushed = 1'b0;
      for (int k = 0; k <= wait_n; k++) begin
        chk("miss_mc_req", mc_req, 1);
        chk("miss_mc_addr", mc_addr, {a[31:2], 2'b00});
        chk("miss_ready", ready, 0);
        chk("miss_no_valid", ivalid, 0);
        mc_valid = (k == wait_n);
        mc_data  = (k == wait_n) ? fill : $urandom;
        cancel   = (k == cancel_at);
        flush    = (k == flush_at);
        if (k == cancel_at) cancelled = 1'b1;
        if (k == flush_at) flushed = 1'b1;
        @(negedge clk);
      end
      mc_valid = 1'b0; cancel = 1'b0; flush = 1'b0;
      if (flushed) m_clear();
      else begin
        m_valid[idx] = 1'b1; m_tag[idx] = a[31:8]; m_data[idx] = fill;
      end
      chk("fill_valid", ivalid, !cancelled);
      if (!cancelled) chk("fill_data", idata, fill);
      chk("fill_mc_req_drop", mc_req, 0);
      chk("fill_ready", ready, 1);
    end
  endtask

  task automatic flush_pulse();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_clear();
  endtask

  task automatic hit_burst(input int n);
    logic [31:0] q[$];
    int prev;
    for (int i = 0; i < 64 && q.size() < n; i++)
      if (m_valid[i]) q.push_back({m_tag[i], 6'(i), 2'($urandom)});
    prev = -1;
    foreach (q[j]) begin
      if (prev >= 0) begin
        chk("burst_valid", ivalid, 1);
        chk("burst_data", idata, m_data[prev]);
      end
      chk("burst_ready", ready, 1);
      req = 1'b1; addr = q[j]; prev = int'(q[j][7:2]);
      @(negedge clk);
    end
    req = 1'b0;
    if (prev >= 0) begin
      chk("burst_valid", ivalid, 1);
      chk("burst_data", idata, m_data[prev]);
    end
  endtask

  task automatic b_access(input logic [31:0] a, input logic [31:0] fill);
    chk("byp_ready", b_ready, 1);
    b_req = 1'b1; b_addr = a;
    @(negedge clk);
    b_req = 1'b0;
    chk("byp_mc_req", b_mc_req, 1);
    chk("byp_mc_addr", b_mc_addr, {a[31:2], 2'b00});
    @(negedge clk);
    chk("byp_mc_req_held", b_mc_req, 1);
    b_mc_valid = 1'b1; b_mc_data = fill;
    @(negedge clk);
    b_mc_valid = 1'b0;
    chk("byp_valid", b_ivalid, 1);
    chk("byp_data", b_idata, fill);
    chk("byp_mc_req_drop", b_mc_req, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, fd;
    int w, ca, fa;
    rst_n = 1'b0; rdy = 1'b1; req = 1'b0; cancel = 1'b0; flush = 1'b0;
    addr = '0; mc_valid = 1'b0; mc_data = '0;
    b_req = 1'b0; b_cancel = 1'b0; b_flush = 1'b0; b_addr = '0; b_mc_valid = 1'b0; b_mc_data = '0;
    m_clear();
    #2;
    chk("rst_ready", ready, 0);
    chk("rst_valid", ivalid, 0);
    chk("rst_data", idata, 0);
    chk("rst_mc_req", mc_req, 0);
    chk("rst_mc_addr", mc_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // cold miss, hit, conflict replacement
    access(32'h0000_1004, 32'h0051_0113, 2, -1, -1, 0, 0);
    chk("hit_expected_0x1006", m_hit(32'h0000_1006), 1);
    access(32'h0000_1006, 32'h0, 0, -1, -1, 0, 0);
    access(32'h0000_1104, 32'h1111_1111, 1, -1, -1, 0, 0);
    access(32'h0000_1004, 32'h0051_0113, 0, -1, -1, 0, 0);

    // cancel during miss, then hit; hit cancelled in its request cycle
    access(32'h0000_2000, 32'hDEAD_BEEF, 3, 1, -1, 0, 0);
    access(32'h0000_2000, 32'h0, 0, -1, -1, 0, 0);
    access(32'h0000_2000, 32'h0, 0, -1, -1, 1, 0);
    access(32'h0000_3008, 32'hCAFE_0001, 2, 2, -1, 0, 0);

    // flush variants
    flush_pulse();
    access(32'h0000_1004, 32'h0051_0113, 2, -1, -1, 0, 0);
    access(32'h0000_1008, 32'h2222_2222, 3, -1, 1, 0, 0);
    access(32'h0000_1008, 32'h2222_2223, 1, -1, -1, 0, 0);
    access(32'h0000_100C, 32'h3333_3333, 2, -1, 2, 0, 0);
    access(32'h0000_100C, 32'h3333_3334, 0, -1, -1, 0, 0);
    access(32'h0000_1008, 32'h4444_4444, 1, -1, -1, 0, 1);

    access(32'h0000_1104, 32'h5555_0000, 0, -1, -1, 0, 0);
    access(32'h0000_2010, 32'h5555_0001, 1, -1, -1, 0, 0);
    hit_burst(6);

    // freeze in MISS: mc_valid, cancel and flush are all ignored while rdy is low
    chk("frz_ready", ready, 1);
    req = 1'b1; addr = 32'h0000_7710;
    @(negedge clk);
    req = 1'b0;
    chk("frz_mc_req", mc_req, 1);
    rdy = 1'b0; mc_valid = 1'b1; mc_data = 32'hBAD0_BAD0; cancel = 1'b1; flush = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("frz_mc_req_held", mc_req, 1);
      chk("frz_mc_addr", mc_addr, 32'h0000_7710);
      chk("frz_no_valid", ivalid, 0);
      chk("frz_ready_low", ready, 0);
    end
    rdy = 1'b1; cancel = 1'b0; flush = 1'b0; mc_valid = 1'b0;
    @(negedge clk);
    chk("frz_after_mc_req", mc_req, 1);
    mc_valid = 1'b1; mc_data = 32'h7777_0110;
    @(negedge clk);
    mc_valid = 1'b0;
    chk("frz_fill_valid", ivalid, 1);
    chk("frz_fill_data", idata, 32'h7777_0110);
    m_valid[4] = 1'b1; m_tag[4] = 24'h000077; m_data[4] = 32'h7777_0110;
    access(32'h0000_7710, 32'h0, 0, -1, -1, 0, 0);
    access(32'h0000_1104, 32'h0, 0, -1, -1, 0, 0);

    // reset mid-miss
    req = 1'b1; addr = 32'h0000_5004;
    @(negedge clk);
    req = 1'b0;
    chk("rmm_mc_req", mc_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rmm_mc_req_async", mc_req, 0);
    chk("rmm_ready_low", ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    mc_valid = 1'b1; mc_data = 32'h1234_5678;
    @(negedge clk);
    mc_valid = 1'b0;
    chk("rmm_stray_fill", ivalid, 0);
    chk("rmm_no_mc_req", mc_req, 0);
    access(32'h0000_1104, 32'h6666_0000, 1, -1, -1, 0, 0);
    access(32'h0000_7710, 32'h6666_0001, 0, -1, -1, 0, 0);

    // random traffic over a small address pool to mix hits and conflicts
    for (int i = 0; i < 200; i++) begin
      a  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      fd = $urandom;
      w  = $urandom_range(0, 3);
      ca = ($urandom_range(0, 3) == 0) ? $urandom_range(0, w) : -1;
      fa = ($urandom_range(0, 5) == 0) ? $urandom_range(0, w) : -1;
      access(a, fd, w, ca, fa, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      if (i % 25 == 24) hit_burst(4);
      if (i % 40 == 39) flush_pulse();
    end

    // bypass instance: same address misses twice, flush is harmless
    b_access(32'h0000_3000, 32'hB0B0_0001);
    b_flush = 1'b1;
    @(negedge clk);
    b_flush = 1'b0;
    b_access(32'h0000_3002, 32'hB0B0_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
